// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one registered 8-bit calculator among NREQ requesters.
// Each transaction: IDLE (grant) -> EXEC -> CAPT -> RESP (valid/ready response).
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic [7:0]        alu_first_num,
    output logic [7:0]        alu_second_num,
    output logic [1:0]        alu_operation,
    input  logic [15:0]       alu_q,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t         state, state_next;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] grant_inc;
    logic           found;
    logic [IDW:0]   cand;
    logic [IDW:0]   inc_w;
    logic [7:0]     sel_a, sel_b;
    logic [1:0]     sel_op;
    logic           accept;

    // Search upward from rr_ptr with wrap; first valid requester wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                grant = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        inc_w = {1'b0, grant} + (IDW+1)'(1);
        if (inc_w >= (IDW+1)'(NREQ))
            inc_w = '0;
        grant_inc = inc_w[IDW-1:0];
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_a  = req_a[i*8 +: 8];
                sel_b  = req_b[i*8 +: 8];
                sel_op = req_op[i*2 +: 2];
            end
        end
    end

    assign accept = (state == IDLE) && found && !reset;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = 1'b0;
        busy       = (state != IDLE) && !reset;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready  = NREQ'(1) << grant;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = CAPT;
            CAPT: state_next = RESP;
            RESP: begin
                rsp_valid = !reset;
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr         <= '0;
            alu_first_num  <= '0;
            alu_second_num <= '0;
            alu_operation  <= '0;
            rsp_id         <= '0;
            rsp_data       <= '0;
        end else begin
            if (accept) begin
                alu_first_num  <= sel_a;
                alu_second_num <= sel_b;
                alu_operation  <= sel_op;
                rsp_id         <= grant;
                rr_ptr         <= grant_inc;
            end
            if (state == CAPT)
                rsp_data <= alu_q;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural registered calculator on alu_*.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ*2-1:0] req_op;
    logic [7:0]        alu_first_num;
    logic [7:0]        alu_second_num;
    logic [1:0]        alu_operation;
    logic [15:0]       alu_q;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_data;
    logic              busy;

    int n_checks;
    int n_pass;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_op         (req_op),
        .alu_first_num  (alu_first_num),
        .alu_second_num (alu_second_num),
        .alu_operation  (alu_operation),
        .alu_q          (alu_q),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Calculator datapath: result registered one cycle after operands; op 11 returns {a,b}.
    always_ff @(posedge clk) begin
        if (reset)
            alu_q <= '0;
        else
            case (alu_operation)
                2'b00:   alu_q <= {8'h00, alu_first_num} + {8'h00, alu_second_num};
                2'b01:   alu_q <= {8'h00, alu_first_num - alu_second_num};
                2'b10:   alu_q <= 16'(alu_first_num) * 16'(alu_second_num);
                default: alu_q <= {alu_first_num, alu_second_num};
            endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        req_a[id*8 +: 8]  = a;
        req_b[id*8 +: 8]  = b;
        req_op[id*2 +: 2] = op;
        req_valid[id]     = 1'b1;
    endtask

    // Called in the IDLE cycle where requester id should be accepted; returns in cycle T+4.
    task automatic run_txn(input int id, input logic [15:0] exp_data,
                           input logic [7:0] ea, input logic [7:0] eb, input logic [1:0] eop);
        logic [NREQ-1:0] onehot;
        onehot = '0;
        onehot[id] = 1'b1;
        check("grant", 32'(req_ready), 32'(onehot));
        check("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_ready", 32'(req_ready), 32'd0);
        check("alu_first", 32'(alu_first_num), 32'(ea));
        check("alu_second", 32'(alu_second_num), 32'(eb));
        check("alu_op", 32'(alu_operation), 32'(eop));
        req_valid[id] = 1'b0;
        @(negedge clk);
        check("capt_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        @(negedge clk);
        check("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        set_req(0, 8'd220, 8'd100, 2'b00);
        set_req(1, 8'd211, 8'd200, 2'b01);
        set_req(2, 8'd200, 8'd200, 2'b10);
        set_req(3, 8'd5,   8'd3,   2'b00);

        // Reset held two cycles with every requester valid
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_alu_first", 32'(alu_first_num), 32'd0);
        check("rst_alu_second", 32'(alu_second_num), 32'd0);
        check("rst_alu_op", 32'(alu_operation), 32'd0);
        reset = 1'b0;
        #1;

        // All four served in round-robin order, one every 4 cycles
        run_txn(0, 16'd320,   8'd220, 8'd100, 2'b00);
        run_txn(1, 16'd11,    8'd211, 8'd200, 2'b01);
        run_txn(2, 16'd40000, 8'd200, 8'd200, 2'b10);
        run_txn(3, 16'd8,     8'd5,   8'd3,   2'b00);

        // Wrap: pointer back at 0 after serving requester 3
        set_req(0, 8'd7,  8'd9,  2'b11);
        set_req(2, 8'd50, 8'd20, 2'b01);
        #1;
        run_txn(0, 16'h0709, 8'd7,  8'd9,  2'b11);
        run_txn(2, 16'd30,   8'd50, 8'd20, 2'b01);

        // Backpressure: response held 5 cycles while requester 0 waits
        rsp_ready = 1'b0;
        set_req(1, 8'd200, 8'd200, 2'b10);
        #1;
        check("bp_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        set_req(0, 8'd1, 8'd2, 2'b00);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'd40000);
            check("bp_rsp_id", 32'(rsp_id), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
            if (k < 4)
                @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        run_txn(0, 16'd3, 8'd1, 8'd2, 2'b00);

        // Reset during CAPT abandons requester 1 and clears the pointer
        set_req(1, 8'd9, 8'd9, 2'b00);
        #1;
        check("ab_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        set_req(0, 8'd4, 8'd6, 2'b10);
        set_req(2, 8'd8, 8'd8, 2'b00);
        @(negedge clk);
        check("ab_capt_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("ab_rsp_valid", 32'(rsp_valid), 32'd0);
        check("ab_rsp_data", 32'(rsp_data), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        run_txn(0, 16'd24, 8'd4, 8'd6, 2'b10);
        run_txn(2, 16'd16, 8'd8, 8'd8, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
